mod6_sync_up_counter: RTL and testbench
=======================================

Name: mod6_sync_up_counter

Overview:
- Synchronous modulo-MOD up counter: counts 0,1,...,MOD-1, then wraps to 0. Default MOD is 6.
- Counterpart to the team's mod-6 ripple down counter. Provides the up-counting direction.
- Fully synchronous single-clock design. No derived clocks and no asynchronous preset paths.
- Provides enable, parallel load, terminal-count and carry-out for cascading, a saturating wrap counter, and a sticky illegal-load flag.

Parameters:
- MOD, 6, modulus; legal count values are 0..MOD-1. Must be >= 2.
- WIDTH, 3, width of Q and load_val. Must satisfy 2^WIDTH >= MOD.
- WRAP_W, 8, width of wrap_cnt.

Ports:
- clk  input  1  rising-edge clock; the only clock.
- rst  input  1  synchronous reset, active-high.
- en  input  1  count enable.
- load  input  1  synchronous parallel load strobe.
- load_val  input  WIDTH  value captured into Q on load.
- Q  output  WIDTH  current count, registered.
- tc  output  1  terminal count; combinational, (Q == MOD-1).
- co  output  1  carry out; combinational, tc & en & ~load. High in the cycle that causes the wrap.
- wrap_cnt  output  WRAP_W  number of MOD-1 -> 0 wraps; registered, saturating.
- load_err  output  1  sticky flag: an out-of-range load was attempted; registered.

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- Reset: sampled on the rising edge of clk only; no effect between edges.
  - On reset: Q=0, wrap_cnt=0, load_err=0.
  - As a result: tc=0, and co=0 whenever Q=0 and MOD>1.
- Priority per edge, highest first: rst > load > en > hold.
- Load (rst=0, load=1):
  - load_val < MOD: Q <= load_val.
  - load_val >= MOD: Q <= 0 and load_err <= 1.
  - Load ignores en.
  - Load never increments wrap_cnt, even when Q == MOD-1.
- Count (rst=0, load=0, en=1):
  - Q < MOD-1: Q <= Q+1.
  - Q == MOD-1: Q <= 0, and wrap_cnt <= wrap_cnt+1 unless wrap_cnt is all ones (saturates; no rollover).
- Hold (rst=0, load=0, en=0): all registers keep their values.
- Latency:
  - Q, wrap_cnt and load_err update one clock after the qualifying inputs are sampled.
  - tc and co follow Q and the inputs combinationally, with zero latency.
- Cascading: a higher digit's en is driven from this block's co. The pair then forms a synchronous mod-(MOD*MOD_hi) counter with no ripple.
- Clearing load_err: only rst clears it. Subsequent legal loads and counting leave it set.
- Q is never allowed to hold a value >= MOD, by any input sequence.
- Reset mid-count overrides load and en in the same cycle.
- Simultaneous load=1 and en=1 with Q==MOD-1: the load wins, co=0, wrap_cnt unchanged.
- No internal state beyond Q, wrap_cnt and load_err.
- Widths: Q+1 is computed at WIDTH+1 bits before the compare, so MOD == 2^WIDTH wraps correctly.

Test Plan:
- Reset then count: rst=1 for 2 cycles, then en=1 for 14 cycles.
  - Q sequence 0,1,2,3,4,5,0,1,2,3,4,5,0,1.
  - tc high when Q=5.
  - co pulses on the 6th and 12th cycles.
  - wrap_cnt ends at 2.
- Enable gating: with Q=3, toggle en 1,0,0,1.
  - Q goes 4,4,4,5.
  - tc rises only at Q=5.
  - co stays 0 throughout, because en=0 whenever Q=5 before the final edge.
- Loads:
  - load_val=4 -> Q=4, load_err stays 0.
  - load_val=7 -> Q=0, load_err=1.
  - Then en=1 for 3 cycles -> Q=3, load_err still 1.
  - rst -> load_err=0.
- Collision at terminal count: Q=5 with en=1, load=1, load_val=2.
  - Next Q=2.
  - co=0 in that cycle.
  - wrap_cnt unchanged.
- Saturation: WRAP_W=2, en=1 for 30 cycles.
  - wrap_cnt goes 1,2,3, then stays 3 at later wraps.
  - Q keeps wrapping normally.
- Reset dominance and cascade:
  - rst=1 together with load=1 and load_val=3 -> Q=0.
  - Two instances chained via co -> en count 0..35 over 36 enabled cycles.
  - High digit increments exactly when the low digit goes 5->0.

Source files
------------

// File: rtl/mod6_sync_up_counter.sv
// rtl/mod6_sync_up_counter.sv - synchronous modulo-MOD up counter with load, carry, wrap count and load error flag
module mod6_sync_up_counter #(
  parameter int MOD    = 6,
  parameter int WIDTH  = 3,
  parameter int WRAP_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              load,
  input  logic [WIDTH-1:0]  load_val,
  output logic [WIDTH-1:0]  Q,
  output logic              tc,
  output logic              co,
  output logic [WRAP_W-1:0] wrap_cnt,
  output logic              load_err
);

  // Modulus and terminal value held one bit wider so MOD == 2^WIDTH still compares correctly.
  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH+1)'(MOD);
  localparam logic [WIDTH-1:0] LAST    = WIDTH'(MOD - 1);

  logic [WIDTH:0]    q_inc;
  logic              load_ok;
  logic              wrap_sat;
  logic [WIDTH-1:0]  q_next;
  logic [WRAP_W-1:0] wrap_next;
  logic              err_next;

  assign q_inc    = {1'b0, Q} + (WIDTH+1)'(1);
  assign load_ok  = ({1'b0, load_val} < MOD_EXT);
  assign wrap_sat = &wrap_cnt;

  // Terminal count and cascade carry are combinational so a higher digit sees them in the same cycle.
  assign tc = (Q == LAST);
  assign co = tc & en & ~load;

  // Next-state selection: load beats count, count beats hold; illegal loads park Q at zero.
  always_comb begin
    q_next    = Q;
    wrap_next = wrap_cnt;
    err_next  = load_err;
    if (load) begin
      if (load_ok) begin
        q_next = load_val;
      end else begin
        q_next   = '0;
        err_next = 1'b1;
      end
    end else if (en) begin
      if (q_inc == MOD_EXT) begin
        q_next = '0;
        if (!wrap_sat) begin
          wrap_next = wrap_cnt + WRAP_W'(1);
        end
      end else begin
        q_next = q_inc[WIDTH-1:0];
      end
    end
  end

  // State registers with synchronous reset that overrides load and enable.
  always_ff @(posedge clk) begin
    if (rst) begin
      Q        <= '0;
      wrap_cnt <= '0;
      load_err <= 1'b0;
    end else begin
      Q        <= q_next;
      wrap_cnt <= wrap_next;
      load_err <= err_next;
    end
  end

endmodule

// File: tb/tb_mod6_sync_up_counter.sv
// tb/tb_mod6_sync_up_counter.sv - randomized and directed self-checking bench for mod6_sync_up_counter
module tb_mod6_sync_up_counter;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b0;
  logic       load = 1'b0;
  logic [2:0] load_val = 3'd0;

  logic [2:0] q_lo, q_sat, q_hi;
  logic       tc_lo, co_lo, tc_sat, co_sat, tc_hi, co_hi;
  logic [7:0] wrap_lo, wrap_hi;
  logic [1:0] wrap_sat;
  logic       err_lo, err_sat, err_hi;

  int total = 0;
  int bad   = 0;

  // reference state: plain integers following the counting rules
  int m_q = 0;
  int m_wrap = 0;
  int m_wrap2 = 0;
  int m_err = 0;
  int m_hi = 0;
  int m_hi_wrap = 0;

  always #5 clk = ~clk;

  mod6_sync_up_counter u_lo (
    .clk(clk), .rst(rst), .en(en), .load(load), .load_val(load_val),
    .Q(q_lo), .tc(tc_lo), .co(co_lo), .wrap_cnt(wrap_lo), .load_err(err_lo)
  );

  mod6_sync_up_counter #(.WRAP_W(2)) u_sat (
    .clk(clk), .rst(rst), .en(en), .load(load), .load_val(load_val),
    .Q(q_sat), .tc(tc_sat), .co(co_sat), .wrap_cnt(wrap_sat), .load_err(err_sat)
  );

  mod6_sync_up_counter u_hi (
    .clk(clk), .rst(rst), .en(co_lo), .load(1'b0), .load_val(3'd0),
    .Q(q_hi), .tc(tc_hi), .co(co_hi), .wrap_cnt(wrap_hi), .load_err(err_hi)
  );

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // one clock: drive inputs, check combinational outputs, clock, advance model, check registers
  task automatic step(input bit r, input bit e, input bit l, input int lv);
    int carry;
    rst = r; en = e; load = l; load_val = 3'(lv);
    #3;
    carry = (m_q == 5 && e && !l) ? 1 : 0;
    chk("tc", int'(tc_lo), (m_q == 5) ? 1 : 0);
    chk("co", int'(co_lo), carry);
    chk("co_sat", int'(co_sat), carry);
    @(posedge clk);
    if (r) begin
      m_q = 0; m_wrap = 0; m_wrap2 = 0; m_err = 0; m_hi = 0; m_hi_wrap = 0;
    end else if (l) begin
      if (lv < 6) m_q = lv;
      else begin
        m_q = 0;
        m_err = 1;
      end
    end else if (e) begin
      if (m_q == 5) begin
        m_q = 0;
        if (m_wrap < 255) m_wrap++;
        if (m_wrap2 < 3) m_wrap2++;
        if (m_hi == 5) begin
          m_hi = 0;
          if (m_hi_wrap < 255) m_hi_wrap++;
        end else m_hi++;
      end else m_q++;
    end
    #1;
    chk("q", int'(q_lo), m_q);
    chk("wrap_cnt", int'(wrap_lo), m_wrap);
    chk("load_err", int'(err_lo), m_err);
    chk("q_sat", int'(q_sat), m_q);
    chk("wrap_sat", int'(wrap_sat), m_wrap2);
    chk("err_sat", int'(err_sat), m_err);
    chk("q_hi", int'(q_hi), m_hi);
    chk("wrap_hi", int'(wrap_hi), m_hi_wrap);
    chk("cascade", int'(q_hi) * 6 + int'(q_lo), m_hi * 6 + m_q);
  endtask

  initial begin
    // initial reset without checks: registers are unknown before the first edge
    rst = 1'b1;
    @(posedge clk);
    #1;

    // reset then count 14 cycles
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    chk("reset_q", int'(q_lo), 0);
    chk("reset_tc", int'(tc_lo), 0);
    for (int i = 0; i < 14; i++) step(0, 1, 0, 0);
    chk("wrap_after_14", int'(wrap_lo), 2);

    // enable gating from Q=3
    step(0, 0, 1, 3);
    step(0, 1, 0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    step(0, 1, 0, 0);
    chk("gated_q", int'(q_lo), 5);

    // loads: legal, illegal, count on, reset clears error
    step(0, 0, 1, 4);
    step(0, 1, 1, 7);
    chk("illegal_err", int'(err_lo), 1);
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0);
    chk("err_sticky", int'(err_lo), 1);
    step(1, 0, 0, 0);
    chk("err_cleared", int'(err_lo), 0);

    // collision of load and enable at terminal count
    step(0, 0, 1, 5);
    step(0, 1, 1, 2);
    chk("collision_q", int'(q_lo), 2);

    // saturation of the 2-bit wrap counter over 30 enabled cycles
    step(1, 0, 0, 0);
    for (int i = 0; i < 30; i++) step(0, 1, 0, 0);
    chk("sat_wrap", int'(wrap_sat), 3);

    // reset dominance over load
    step(0, 0, 1, 4);
    step(1, 1, 1, 3);
    chk("rst_dom_q", int'(q_lo), 0);

    // cascade through full 36-state cycle
    for (int i = 0; i < 36; i++) step(0, 1, 0, 0);
    chk("cascade_wrap_hi", int'(wrap_hi), 1);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 39) == 0),
           ($urandom_range(0, 2) != 0),
           ($urandom_range(0, 5) == 0),
           int'($urandom_range(0, 7)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
